// File: rtl/ctrl_frame_serializer.sv
// ctrl_frame_serializer
// Accepts one parallel control frame (VREF/DATA/CONVER/COMP + temp) over a
// valid/ready handshake and shifts every field out on its own serial lane,
// MSB first, behind a leading '1' marker bit. Once the longest lane has
// finished, a one-cycle stop pulse carries the captured temp bit downstream.
//
// Handshake: a frame is taken on a rising edge where load_valid and
// load_ready are both high; load_ready is high only while the FSM is IDLE,
// and load_valid while busy is ignored.
//
// Optional build macro: CTRL_SER_ABORT_EN adds an abort input and an aborted
// output pulse. The default build (macro undefined) has neither port.
module ctrl_frame_serializer #(
  parameter int VREF_W = 4,
  parameter int DATA_W = 8,
  parameter int CONV_W = 8,
  parameter int COMP_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [VREF_W-1:0] vref_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CONV_W-1:0] conv_in,
  input  logic [COMP_W-1:0] comp_in,
  input  logic              temp_in,
  output logic              out_vref,
  output logic              out_data,
  output logic              out_conver,
  output logic              out_comp,
  output logic              out_stop,
  output logic              out_temp,
  output logic              busy,
  output logic              done,
`ifdef CTRL_SER_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic [1:0]        state_dbg
);

  localparam int MAX_VD = (VREF_W > DATA_W) ? VREF_W : DATA_W;
  localparam int MAX_CC = (CONV_W > COMP_W) ? CONV_W : COMP_W;
  localparam int MAX_W  = (MAX_VD > MAX_CC) ? MAX_VD : MAX_CC;
  localparam int CNT_W  = $clog2(MAX_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [VREF_W-1:0] vref_sh;
  logic [DATA_W-1:0] data_sh;
  logic [CONV_W-1:0] conv_sh;
  logic [COMP_W-1:0] comp_sh;
  logic              temp_q;

  // Ready is a pure decode of the state so the upstream sees it in IDLE only.
  assign load_ready = (state == IDLE);
  assign state_dbg  = state;

  // Frame FSM: capture, shift the lanes MSB first, then issue the stop pulse.
  // Each lane is a left-shifting register whose MSB becomes the next serial
  // bit; zeros shifted in keep short lanes low once their payload is gone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      vref_sh    <= '0;
      data_sh    <= '0;
      conv_sh    <= '0;
      comp_sh    <= '0;
      temp_q     <= 1'b0;
      out_vref   <= 1'b0;
      out_data   <= 1'b0;
      out_conver <= 1'b0;
      out_comp   <= 1'b0;
      out_stop   <= 1'b0;
      out_temp   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef CTRL_SER_ABORT_EN
      aborted    <= 1'b0;
`endif
    end else begin
      out_stop <= 1'b0;
      done     <= 1'b0;
`ifdef CTRL_SER_ABORT_EN
      aborted  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (load_valid) begin
            vref_sh    <= vref_in;
            data_sh    <= data_in;
            conv_sh    <= conv_in;
            comp_sh    <= comp_in;
            temp_q     <= temp_in;
            cnt        <= '0;
            out_vref   <= 1'b1;
            out_data   <= 1'b1;
            out_conver <= 1'b1;
            out_comp   <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (cnt == CNT_W'(MAX_W)) begin
            out_vref   <= 1'b0;
            out_data   <= 1'b0;
            out_conver <= 1'b0;
            out_comp   <= 1'b0;
            out_stop   <= 1'b1;
            done       <= 1'b1;
            out_temp   <= temp_q;
            state      <= LATCH;
          end else begin
            cnt        <= cnt + CNT_W'(1);
            out_vref   <= vref_sh[VREF_W-1];
            out_data   <= data_sh[DATA_W-1];
            out_conver <= conv_sh[CONV_W-1];
            out_comp   <= comp_sh[COMP_W-1];
            vref_sh    <= vref_sh << 1;
            data_sh    <= data_sh << 1;
            conv_sh    <= conv_sh << 1;
            comp_sh    <= comp_sh << 1;
          end
        end
        LATCH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
`ifdef CTRL_SER_ABORT_EN
      // Abort overrides the frame: lanes and stop drop, no done for it.
      if (abort && (state != IDLE)) begin
        out_vref   <= 1'b0;
        out_data   <= 1'b0;
        out_conver <= 1'b0;
        out_comp   <= 1'b0;
        out_stop   <= 1'b0;
        done       <= 1'b0;
        busy       <= 1'b0;
        cnt        <= '0;
        aborted    <= 1'b1;
        state      <= IDLE;
      end
`endif
    end
  end

endmodule
